ppu_reg_port: RTL
=================

// Module: ppu_reg_port
// PURPOSE
//   CPU-facing register responder for the PPU window $2000-$3FFF, mirrored every 8 bytes.
//   Decodes CPU bus cycles into ctrl, mask, status, OAM, scroll and VRAM-address registers.
//   Runs the $2007 VRAM access FSM and returns read data to the CPU data-in mux.
//   Sits between the cpu bus (ea/dout/wreq/rd) and the PPU renderer / VRAM arbiter.
// PARAMETERS
//   SEL_HI   3'b001  value of ea[15:13] that selects this block
//   VADDR_W  14      VRAM address width; v wraps modulo 2**VADDR_W
// PORTS
//   clk         in   1   100 MHz system clock
//   rst         in   1   synchronous, active-high reset
//   ce          in   1   CPU clock-enable pulse; a bus access is sampled only when ce=1
//   ea          in   16  CPU effective address
//   wdata       in   8   CPU write data
//   wreq        in   1   CPU write strobe
//   rd          in   1   CPU read strobe
//   rdata       out  8   register read data; registered; valid the clk after the access; held until the next read
//   ctrl, mask  out  8   $2000 / $2001 register contents
//   scroll_x/y  out  8   $2005 first / second write
//   vaddr_t     out  14  $2006 temporary address
//   oam_addr    out  8   $2003 register
//   oam_we      out  1   one-clk pulse; write wdata at oam_addr
//   vram_addr   out  14  VRAM address for the $2007 cycle
//   vram_wdata  out  8   VRAM write data
//   vram_req    out  1   high while a $2007 access is pending
//   vram_we     out  1   qualifies vram_req as a write
//   vram_gnt    in   1   arbiter grant; a granted read returns data 1 clk later
//   vram_rdata  in   8   VRAM read data
//   vbl_start   in   1   one-clk pulse from the renderer; sets vblank
//   vbl_end     in   1   one-clk pulse from the renderer; clears vblank, spr0 and ovf
//   spr0, sovf  in   1   sprite-0 hit and overflow, reflected live in status
//   nmi         out  1   equals ctrl[7] & vblank (registered)
//   busy, ovr   out  1   FSM not idle / sticky flag for a dropped $2007 access (cleared by rst)
// BEHAVIOUR
// - Access: fires on a clk with ce & (ea[15:13]==SEL_HI) & (wreq|rd).
//   - Register = ea[2:0].
//   - wreq has priority over rd.
//   - Exactly one access per ce pulse.
// - Reset values: every output and register is 0, w=0, v=0, read buffer=0, FSM IDLE.
// - $2000 write: ctrl<=wdata. $2001 write: mask<=wdata. $2003 write: oam_addr<=wdata.
// - $2004 write: oam_we pulses for one clk, then oam_addr increments, 255 wraps to 0.
// - $2005 write: w=0 loads scroll_x, w=1 loads scroll_y; w toggles.
// - $2006 write:
//   - w=0: vaddr_t[13:8]<=wdata[5:0].
//   - w=1: vaddr_t[7:0]<=wdata, and v<=new vaddr_t in the same clk.
//   - w toggles.
// - $2002 read:
//   - rdata = {vblank, spr0, sovf, last_wdata[4:0]}, where last_wdata is the last written byte (open bus).
//   - Then vblank<=0 and w<=0.
// - vblank/vbl_start collision: if vbl_start coincides with a $2002 read, the read returns bit7=0 and the set is suppressed.
// - Set/clear collision: vbl_start and vbl_end in the same clk -> vbl_end wins.
// - Reads of write-only registers return last_wdata.
// - $2007 FSM, states IDLE -> REQ -> DATA -> IDLE:
//   - Access in IDLE: latch vram_addr<=v and vram_we=wreq, then go to REQ.
//   - v advances in the access clk: v += ctrl[2] ? 32 : 1, modulo 2**VADDR_W.
//   - REQ: vram_req=1 and held until vram_gnt.
//   - Write granted: go to IDLE.
//   - Read granted: go to DATA.
//   - DATA: read buffer<=vram_rdata, then go to IDLE.
// - $2007 read data: rdata = the buffer value before the access (one-read latency). No palette bypass.
// - $2007 access while busy: dropped, v unchanged, ovr<=1. A non-$2007 access while busy is served normally.
// - Rendering-time VRAM reads are the arbiter's concern, not this block's.
// - rst in any state: FSM returns to IDLE in the next clk and vram_req/vram_we drop; no partial VRAM write is committed.
// - ce=0: no access is decoded. vbl pulses and the FSM still advance on clk.
// TESTING
// 1. Reset -> all outputs 0. vbl_start with ctrl=0 -> nmi stays 0. Write $2000=0x80 -> nmi=1 next clk.
// 2. $2006=0x21, $2006=0x08, $2007=0xAA with gnt=1 -> VRAM write 0xAA at 0x2108, v=0x2109; repeat with ctrl[2]=1 -> v=0x2128.
// 3. VRAM[0x2108]=0x55; set v=0x2108; read $2007 twice -> first read returns 0x00, second returns 0x55.
// 4. vblank=1; read $2002 -> bit7=1, nmi falls. Then $2005=0x12 -> scroll_x=0x12, proving w was cleared.
// 5. $2003=0xFF; $2004 twice -> oam_we at 0xFF, then at 0x00.
// 6. Hold gnt=0 with a $2007 access pending, issue a second $2007 -> ovr=1, v unchanged. Assert rst mid-REQ -> IDLE, vram_req=0.
// 7. vbl_start coincident with a $2002 read -> returns bit7=0, vblank stays 0.

Source files
------------

// File: rtl/ppu_reg_port.sv
// CPU-facing register responder for the PPU window $2000-$3FFF, mirrored every 8 bytes.
// Decodes CPU accesses into the PPU registers and runs the $2007 VRAM access sequence.
module ppu_reg_port #(
    parameter logic [2:0] SEL_HI  = 3'b001,
    parameter int         VADDR_W = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic [15:0]        ea,
    input  logic [7:0]         wdata,
    input  logic               wreq,
    input  logic               rd,
    output logic [7:0]         rdata,
    output logic [7:0]         ctrl,
    output logic [7:0]         mask,
    output logic [7:0]         scroll_x,
    output logic [7:0]         scroll_y,
    output logic [VADDR_W-1:0] vaddr_t,
    output logic [7:0]         oam_addr,
    output logic               oam_we,
    output logic [VADDR_W-1:0] vram_addr,
    output logic [7:0]         vram_wdata,
    output logic               vram_req,
    output logic               vram_we,
    input  logic               vram_gnt,
    input  logic [7:0]         vram_rdata,
    input  logic               vbl_start,
    input  logic               vbl_end,
    input  logic               spr0,
    input  logic               sovf,
    output logic               nmi,
    output logic               busy,
    output logic               ovr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic               access, acc_wr, acc_rd, status_rd;
    logic               vram_go, vram_drop;
    logic [2:0]         reg_sel;
    logic               w_q, vblank_q, vblank_nxt, we_q;
    logic [VADDR_W-1:0] v_q;
    logic [7:0]         rd_buf_q, last_wdata_q, ctrl_nxt, status;
    logic               unused_ea;

    assign unused_ea = ^ea[12:3];

    assign access    = ce && (ea[15:13] == SEL_HI) && (wreq || rd);
    assign acc_wr    = access && wreq;
    assign acc_rd    = access && !wreq;
    assign reg_sel   = ea[2:0];
    assign status_rd = acc_rd && (reg_sel == 3'd2);
    assign vram_go   = access && (reg_sel == 3'd7) && (state_q == IDLE);
    assign vram_drop = access && (reg_sel == 3'd7) && (state_q != IDLE);
    assign busy      = (state_q != IDLE);
    assign ctrl_nxt  = (acc_wr && reg_sel == 3'd0) ? wdata : ctrl;

    // A vbl_start landing on the $2002 read is hidden from that read and then lost.
    assign status = {vblank_q && !vbl_start, spr0, sovf, last_wdata_q[4:0]};

    always_comb begin
        vblank_nxt = vblank_q;
        if (vbl_end || status_rd) vblank_nxt = 1'b0;
        else if (vbl_start)       vblank_nxt = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        vram_req = 1'b0;
        vram_we  = 1'b0;
        case (state_q)
            IDLE: if (vram_go) state_d = REQ;
            REQ: begin
                vram_req = 1'b1;
                vram_we  = we_q;
                if (vram_gnt) state_d = we_q ? IDLE : DATA;
            end
            DATA:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata        <= '0;
            ctrl         <= '0;
            mask         <= '0;
            scroll_x     <= '0;
            scroll_y     <= '0;
            vaddr_t      <= '0;
            oam_addr     <= '0;
            oam_we       <= 1'b0;
            vram_addr    <= '0;
            vram_wdata   <= '0;
            nmi          <= 1'b0;
            ovr          <= 1'b0;
            w_q          <= 1'b0;
            vblank_q     <= 1'b0;
            we_q         <= 1'b0;
            v_q          <= '0;
            rd_buf_q     <= '0;
            last_wdata_q <= '0;
        end else begin
            vblank_q <= vblank_nxt;
            ctrl     <= ctrl_nxt;
            nmi      <= ctrl_nxt[7] && vblank_nxt;
            oam_we   <= acc_wr && (reg_sel == 3'd4);

            if (acc_wr && reg_sel == 3'd3) oam_addr <= wdata;
            else if (oam_we)               oam_addr <= oam_addr + 8'd1;

            if (acc_wr) begin
                last_wdata_q <= wdata;
                case (reg_sel)
                    3'd1: mask <= wdata;
                    3'd5: begin
                        if (w_q) scroll_y <= wdata;
                        else     scroll_x <= wdata;
                        w_q <= !w_q;
                    end
                    3'd6: begin
                        if (w_q) begin
                            vaddr_t[7:0] <= wdata;
                            v_q          <= {vaddr_t[VADDR_W-1:8], wdata};
                        end else begin
                            vaddr_t[VADDR_W-1:8] <= wdata[VADDR_W-9:0];
                        end
                        w_q <= !w_q;
                    end
                    default: ;
                endcase
            end

            if (acc_rd) begin
                case (reg_sel)
                    3'd2:    rdata <= status;
                    3'd7:    if (vram_go) rdata <= rd_buf_q;
                    default: rdata <= last_wdata_q;
                endcase
            end
            if (status_rd) w_q <= 1'b0;

            if (vram_go) begin
                vram_addr <= v_q;
                we_q      <= acc_wr;
                if (acc_wr) vram_wdata <= wdata;
                v_q <= v_q + (ctrl[2] ? VADDR_W'(32) : VADDR_W'(1));
            end
            if (vram_drop)        ovr      <= 1'b1;
            if (state_q == DATA)  rd_buf_q <= vram_rdata;
        end
    end

endmodule
